// File: rtl/bp_me_cache_pkt_decoupler.sv
// ---------------------------------------------------------------------------
// bp_me_cache_pkt_decoupler
//
// Decouples the L2 cache controller's cache-side port from a bsg_cache
// instance. Outgoing cache packets are buffered in a small request FIFO.
// Returning cache data is buffered in a return-data FIFO. A credit counter
// limits the number of requests in flight, so the return-data FIFO can never
// overflow. The cache's data output can therefore always be accepted.
// Packets are carried opaquely and order is preserved on both paths.
//
// Ports
//   clk_i              clock
//   reset_n_i          asynchronous active-low reset (release is synchronized)
//   pkt_i/pkt_v_i      packet from the controller
//   pkt_yumi_o         packet consumed this cycle
//   data_o/data_v_o    return data toward the controller
//   data_yumi_i        controller consumed data_o
//   cache_pkt_o/_v_o   packet to bsg_cache
//   cache_pkt_yumi_i   cache consumed the packet
//   cache_data_i/_v_i  data from bsg_cache
//   cache_data_yumi_o  cache data consumed (always, once out of reset)
//   credits_used_o     requests accepted but not yet returned upstream
// ---------------------------------------------------------------------------

// Simple ready/valid FIFO with its head visible combinationally.
// Ports: data_i/v_i enqueue, yumi_i dequeue, data_o head, empty_o/full_o.
// Enqueue on full and dequeue on empty are ignored, so the pointers stay sane.
module bp_me_cache_pkt_decoupler_fifo #(
  parameter int width_p = 8,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  input  logic               yumi_i,
  output logic [width_p-1:0] data_o,
  output logic               empty_o,
  output logic               full_o
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);
  localparam logic [ptr_w_lp-1:0] last_lp = ptr_w_lp'(els_p - 1);
  localparam logic [cnt_w_lp-1:0] els_lp  = cnt_w_lp'(els_p);

  logic [width_p-1:0]  mem_reg [els_p];
  logic [ptr_w_lp-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ptr_w_lp-1:0] rd_ptr_reg, rd_ptr_next;
  logic [cnt_w_lp-1:0] count_reg, count_next;
  logic                enq, deq;

  assign empty_o = (count_reg == '0);
  assign full_o  = (count_reg == els_lp);
  assign enq     = v_i & ~full_o;
  assign deq     = yumi_i & ~empty_o;

  // Pointers wrap explicitly, so a depth that is not a power of two works too.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (enq) wr_ptr_next = (wr_ptr_reg == last_lp) ? '0 : wr_ptr_reg + ptr_w_lp'(1);
    if (deq) rd_ptr_next = (rd_ptr_reg == last_lp) ? '0 : rd_ptr_reg + ptr_w_lp'(1);
    count_next = count_reg + cnt_w_lp'(enq) - cnt_w_lp'(deq);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (enq) mem_reg[wr_ptr_reg] <= data_i;
  end

  // The head is read combinationally. A write becomes visible the next cycle,
  // which gives the single-cycle latency through each path.
  assign data_o = mem_reg[rd_ptr_reg];

endmodule

module bp_me_cache_pkt_decoupler #(
  parameter int pkt_width_p  = 102,
  parameter int data_width_p = 64,
  parameter int els_p        = 4,
  parameter int req_els_p    = 2,
  localparam int credit_width_lp = $clog2(els_p + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,

  input  logic [pkt_width_p-1:0]     pkt_i,
  input  logic                       pkt_v_i,
  output logic                       pkt_yumi_o,

  output logic [data_width_p-1:0]    data_o,
  output logic                       data_v_o,
  input  logic                       data_yumi_i,

  output logic [pkt_width_p-1:0]     cache_pkt_o,
  output logic                       cache_pkt_v_o,
  input  logic                       cache_pkt_yumi_i,

  input  logic [data_width_p-1:0]    cache_data_i,
  input  logic                       cache_data_v_i,
  output logic                       cache_data_yumi_o,

  output logic [credit_width_lp-1:0] credits_used_o
);

  localparam logic [credit_width_lp-1:0] credit_max_lp = credit_width_lp'(els_p);

  logic [1:0]                 rst_sync_reg;
  logic                       rst_n_int;
  logic                       req_empty, req_full;
  logic                       data_empty, data_full;
  logic                       credit_inc, credit_dec;
  logic [credit_width_lp-1:0] credits_reg, credits_next;

  // Reset asserts immediately and releases two clocks after reset_n_i rises.
  // All internal state uses the synchronized reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) rst_sync_reg <= 2'b00;
    else            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign rst_n_int = rst_sync_reg[1];

  // Request path. Acceptance depends only on pkt_v_i and registered state.
  // The credit check ensures that every accepted packet has room in the
  // return-data FIFO.
  assign pkt_yumi_o = pkt_v_i & rst_n_int & ~req_full & (credits_reg != credit_max_lp);

  bp_me_cache_pkt_decoupler_fifo #(
    .width_p (pkt_width_p),
    .els_p   (req_els_p)
  ) req_fifo (
    .clk_i     (clk_i),
    .reset_n_i (rst_n_int),
    .data_i    (pkt_i),
    .v_i       (pkt_yumi_o),
    .yumi_i    (cache_pkt_yumi_i),
    .data_o    (cache_pkt_o),
    .empty_o   (req_empty),
    .full_o    (req_full)
  );

  assign cache_pkt_v_o = ~req_empty;

  // Return path. Data is always taken, because credits guarantee that a
  // slot is available.
  assign cache_data_yumi_o = cache_data_v_i & rst_n_int;

  bp_me_cache_pkt_decoupler_fifo #(
    .width_p (data_width_p),
    .els_p   (els_p)
  ) data_fifo (
    .clk_i     (clk_i),
    .reset_n_i (rst_n_int),
    .data_i    (cache_data_i),
    .v_i       (cache_data_yumi_o),
    .yumi_i    (data_yumi_i),
    .data_o    (data_o),
    .empty_o   (data_empty),
    .full_o    (data_full)
  );

  assign data_v_o = ~data_empty;

  // Credits: a credit is held from packet acceptance until its data word is
  // consumed upstream. The count saturates at both ends instead of wrapping.
  assign credit_inc = pkt_yumi_o;
  assign credit_dec = data_v_o & data_yumi_i;

  always_comb begin
    credits_next = credits_reg;
    if (credit_inc & ~credit_dec) begin
      if (credits_reg != credit_max_lp) credits_next = credits_reg + credit_width_lp'(1);
    end else if (credit_dec & ~credit_inc) begin
      if (credits_reg != '0) credits_next = credits_reg - credit_width_lp'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_int) begin
    if (!rst_n_int) credits_reg <= '0;
    else            credits_reg <= credits_next;
  end

  assign credits_used_o = credits_reg;

`ifndef SYNTHESIS
  a_data_yumi_without_v: assert property (@(posedge clk_i) disable iff (!rst_n_int)
    data_yumi_i |-> data_v_o)
    else $error("data_yumi_i asserted without data_v_o");

  a_cache_pkt_yumi_without_v: assert property (@(posedge clk_i) disable iff (!rst_n_int)
    cache_pkt_yumi_i |-> cache_pkt_v_o)
    else $error("cache_pkt_yumi_i asserted without cache_pkt_v_o");

  a_cache_data_on_full: assert property (@(posedge clk_i) disable iff (!rst_n_int)
    cache_data_v_i |-> ~data_full)
    else $error("cache_data_v_i while return-data FIFO is full");

  a_credit_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_int)
    (credit_inc & ~credit_dec) |-> (credits_reg != credit_max_lp))
    else $error("credit counter overflow");

  a_credit_underflow: assert property (@(posedge clk_i) disable iff (!rst_n_int)
    (credit_dec & ~credit_inc) |-> (credits_reg != '0))
    else $error("credit counter underflow");
`endif

endmodule

// File: tb/tb_bp_me_cache_pkt_decoupler.sv
// ---------------------------------------------------------------------------
// Testbench for bp_me_cache_pkt_decoupler (els_p=4, req_els_p=2).
// The testbench runs a directed vector table for the credit limit and for
// simultaneous accept/retire. It then runs hand-written sequences for reset,
// backpressure, ordering and throughput, followed by randomized traffic.
// A queue-based reference model checks every output on every cycle.
// ---------------------------------------------------------------------------
module tb_bp_me_cache_pkt_decoupler;

  localparam int PW  = 102;
  localparam int DW  = 64;
  localparam int ELS = 4;
  localparam int REQ = 2;
  localparam int NV  = 11;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic [PW-1:0] pkt_i;
  logic          pkt_v_i;
  logic          pkt_yumi_o;
  logic [DW-1:0] data_o;
  logic          data_v_o;
  logic          data_yumi_i;
  logic [PW-1:0] cache_pkt_o;
  logic          cache_pkt_v_o;
  logic          cache_pkt_yumi_i;
  logic [DW-1:0] cache_data_i;
  logic          cache_data_v_i;
  logic          cache_data_yumi_o;
  logic [2:0]    credits_used_o;

  always #5 clk_i = ~clk_i;

  bp_me_cache_pkt_decoupler #(
    .pkt_width_p  (PW),
    .data_width_p (DW),
    .els_p        (ELS),
    .req_els_p    (REQ)
  ) dut (
    .clk_i             (clk_i),
    .reset_n_i         (reset_n_i),
    .pkt_i             (pkt_i),
    .pkt_v_i           (pkt_v_i),
    .pkt_yumi_o        (pkt_yumi_o),
    .data_o            (data_o),
    .data_v_o          (data_v_o),
    .data_yumi_i       (data_yumi_i),
    .cache_pkt_o       (cache_pkt_o),
    .cache_pkt_v_o     (cache_pkt_v_o),
    .cache_pkt_yumi_i  (cache_pkt_yumi_i),
    .cache_data_i      (cache_data_i),
    .cache_data_v_i    (cache_data_v_i),
    .cache_data_yumi_o (cache_data_yumi_o),
    .credits_used_o    (credits_used_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the block as three FIFOs of contents plus a credit count.
  logic [PW-1:0] req_q[$];    // accepted, not yet taken by the cache
  logic [PW-1:0] pend_q[$];   // taken by the cache, data not yet returned
  logic [DW-1:0] data_q[$];   // returned by the cache, not yet consumed
  int            credits;
  int            rel;         // clock edges seen since reset release

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] rand_pkt();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[PW-1:0];
  endfunction

  // The modelled cache turns a packet into a data word.
  function automatic logic [DW-1:0] cache_resp(input logic [PW-1:0] p);
    return p[DW-1:0] + 64'h90;
  endfunction

  // One clock cycle. The task starts and ends at a negedge. The *_w arguments
  // are requests that are applied only where the protocol allows them.
  task automatic step(input bit rst_n, input bit pv, input logic [PW-1:0] p,
                      input bit cpy_w, input bit cdv_w, input bit dy_w, input bit zero_lat,
                      output bit got_yumi, output bit got_dx, output logic [DW-1:0] got_data);
    logic [PW-1:0] head;
    bit exp_yumi, ready, early, cdv_take;
    reset_n_i = rst_n;
    if (!rst_n) begin
      req_q.delete(); pend_q.delete(); data_q.delete();
      credits = 0; rel = 0;
    end
    ready = (rel >= 2);
    pkt_v_i = pv;
    pkt_i = p;
    cache_pkt_yumi_i = cpy_w && (req_q.size() > 0);
    head = (req_q.size() > 0) ? req_q[0] : '0;
    early = cache_pkt_yumi_i && zero_lat;
    if (early) pend_q.push_back(head);
    cache_data_v_i = cdv_w && (pend_q.size() > 0);
    cache_data_i = (pend_q.size() > 0) ? cache_resp(pend_q[0]) : DW'($urandom);
    data_yumi_i = dy_w && (data_q.size() > 0);
    #1;
    exp_yumi = pv && ready && (req_q.size() < REQ) && (credits < ELS);
    chk("pkt_yumi_o", pkt_yumi_o, exp_yumi);
    chk("cache_pkt_v_o", cache_pkt_v_o, req_q.size() > 0);
    if (req_q.size() > 0) chk("cache_pkt_o", cache_pkt_o, head);
    chk("data_v_o", data_v_o, data_q.size() > 0);
    if (data_q.size() > 0) chk("data_o", data_o, data_q[0]);
    chk("credits_used_o", credits_used_o, credits);
    chk("cache_data_yumi_o", cache_data_yumi_o, cache_data_v_i && ready);
    got_yumi = pkt_yumi_o;
    got_dx = data_v_o && data_yumi_i;
    got_data = data_o;
    cdv_take = cache_data_v_i && ready;
    if (cache_pkt_yumi_i) begin
      void'(req_q.pop_front());
      if (!early) pend_q.push_back(head);
    end
    if (exp_yumi) req_q.push_back(p);
    if (cdv_take) begin
      data_q.push_back(cache_data_i);
      void'(pend_q.pop_front());
    end
    if (data_yumi_i) void'(data_q.pop_front());
    credits = credits + int'(exp_yumi) - int'(data_yumi_i);
    if (rst_n && rel < 2) rel++;
    @(negedge clk_i);
  endtask

  typedef struct {
    logic          pv;
    logic [PW-1:0] p;
    logic          cpy;
    logic          cdv;
    logic [DW-1:0] cd;
    logic          dy;
    logic          e_yumi;
    logic          e_cpv;
    logic [PW-1:0] e_cpkt;
    logic          e_dv;
    logic [DW-1:0] e_data;
    logic [2:0]    e_cred;
  } vec_t;

  vec_t vecs[NV];

  function automatic vec_t mk(input logic pv, input int pn, input logic cpy, input logic cdv,
                              input int dn, input logic dy, input logic e_yumi, input logic e_cpv,
                              input int e_pn, input logic e_dv, input int e_dn, input int e_cred);
    vec_t v;
    v.pv = pv;          v.p = PW'(32'h100 + pn);
    v.cpy = cpy;        v.cdv = cdv;
    v.cd = DW'(32'hD0 + dn);
    v.dy = dy;          v.e_yumi = e_yumi;
    v.e_cpv = e_cpv;    v.e_cpkt = PW'(32'h100 + e_pn);
    v.e_dv = e_dv;      v.e_data = DW'(32'hD0 + e_dn);
    v.e_cred = 3'(e_cred);
    return v;
  endfunction

  bit            y, d;
  logic [DW-1:0] dval;
  logic [PW-1:0] first_pkt;
  logic [DW-1:0] got_q[$];
  int            ny, nd, sent, first_dv;

  initial begin
    // Credit limit, retire, and simultaneous accept/retire at credits_used=3.
    //             pv pn cpy cdv dn dy | yumi cpv cpn dv dn cred
    vecs[0]  = mk(1, 1, 0, 0, 0, 0,    1, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 2, 1, 0, 0, 0,    1, 1, 1, 0, 0, 1);
    vecs[2]  = mk(1, 3, 1, 1, 1, 0,    1, 1, 2, 0, 0, 2);
    vecs[3]  = mk(1, 4, 1, 1, 2, 0,    1, 1, 3, 1, 1, 3);
    vecs[4]  = mk(1, 5, 1, 1, 3, 0,    0, 1, 4, 1, 1, 4);
    vecs[5]  = mk(1, 5, 0, 1, 4, 0,    0, 0, 0, 1, 1, 4);
    vecs[6]  = mk(1, 5, 0, 0, 0, 1,    0, 0, 0, 1, 1, 4);
    vecs[7]  = mk(1, 5, 0, 0, 0, 0,    1, 0, 0, 1, 2, 3);
    vecs[8]  = mk(1, 6, 0, 0, 0, 1,    0, 1, 5, 1, 2, 4);
    vecs[9]  = mk(1, 6, 0, 0, 0, 1,    1, 1, 5, 1, 3, 3);
    vecs[10] = mk(0, 6, 0, 0, 0, 0,    0, 1, 5, 1, 4, 3);

    reset_n_i = 1'b0;
    pkt_v_i = 1'b0; pkt_i = '0; cache_pkt_yumi_i = 1'b0;
    cache_data_v_i = 1'b0; cache_data_i = '0; data_yumi_i = 1'b0;
    credits = 0; rel = 0;
    @(negedge clk_i);

    // Reset state, with a packet presented during reset.
    for (int i = 0; i < 3; i++) step(0, 1, rand_pkt(), 1, 1, 1, 0, y, d, dval);
    for (int i = 0; i < 3; i++) step(1, 0, '0, 0, 0, 0, 0, y, d, dval);

    // Directed table
    for (int i = 0; i < NV; i++) begin
      pkt_v_i = vecs[i].pv; pkt_i = vecs[i].p;
      cache_pkt_yumi_i = vecs[i].cpy; cache_data_v_i = vecs[i].cdv;
      cache_data_i = vecs[i].cd; data_yumi_i = vecs[i].dy;
      #1;
      chk($sformatf("vec%0d_pkt_yumi_o", i), pkt_yumi_o, vecs[i].e_yumi);
      chk($sformatf("vec%0d_cache_pkt_v_o", i), cache_pkt_v_o, vecs[i].e_cpv);
      if (vecs[i].e_cpv) chk($sformatf("vec%0d_cache_pkt_o", i), cache_pkt_o, vecs[i].e_cpkt);
      chk($sformatf("vec%0d_data_v_o", i), data_v_o, vecs[i].e_dv);
      if (vecs[i].e_dv) chk($sformatf("vec%0d_data_o", i), data_o, vecs[i].e_data);
      chk($sformatf("vec%0d_credits_used_o", i), credits_used_o, vecs[i].e_cred);
      chk($sformatf("vec%0d_cache_data_yumi_o", i), cache_data_yumi_o, vecs[i].cdv);
      @(negedge clk_i);
    end

    // Reset with three requests in flight: everything drops immediately.
    reset_n_i = 1'b0; pkt_v_i = 1'b1; cache_pkt_yumi_i = 1'b0;
    cache_data_v_i = 1'b1; data_yumi_i = 1'b0;
    #1;
    chk("rst_mid_pkt_yumi_o", pkt_yumi_o, 1'b0);
    chk("rst_mid_cache_pkt_v_o", cache_pkt_v_o, 1'b0);
    chk("rst_mid_data_v_o", data_v_o, 1'b0);
    chk("rst_mid_cache_data_yumi_o", cache_data_yumi_o, 1'b0);
    chk("rst_mid_credits_used_o", credits_used_o, 3'd0);
    req_q.delete(); pend_q.delete(); data_q.delete(); credits = 0; rel = 0;
    @(negedge clk_i);
    for (int i = 0; i < 3; i++) step(1, 0, '0, 0, 0, 0, 0, y, d, dval);

    // Cache backpressure: only REQ packets get in, and the head holds steady.
    first_pkt = rand_pkt();
    ny = 0;
    for (int c = 0; c < 10; c++) begin
      step(1, 1, (c == 0) ? first_pkt : rand_pkt(), 0, 0, 0, 0, y, d, dval);
      ny += int'(y);
      chk("bp_cache_pkt_stable", cache_pkt_o, first_pkt);
    end
    chk("bp_accept_count", ny, REQ);
    for (int c = 0; c < 30; c++) step(1, 0, '0, 1, 1, 1, 0, y, d, dval);
    chk("bp_drained_credits", credits_used_o, 3'd0);

    // Ordering with random cache gaps and random upstream consumption.
    sent = 0;
    for (int c = 0; c < 300 && got_q.size() < 4; c++) begin
      step(1, sent < 4, PW'(32'h11 + sent), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 0, y, d, dval);
      if (y) sent++;
      if (d) got_q.push_back(dval);
    end
    chk("order_count", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      chk($sformatf("order_data%0d", i), got_q[i], DW'(32'hA1 + i));

    // Randomized traffic
    for (int c = 0; c < 3000; c++)
      step(1, 1'($urandom_range(0, 1)), rand_pkt(), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), y, d, dval);

    // Throughput: everything ready, zero-latency cache.
    for (int c = 0; c < 30; c++) step(1, 0, '0, 1, 1, 1, 0, y, d, dval);
    ny = 0; nd = 0; first_dv = -1;
    for (int c = 0; c < 30; c++) begin
      step(1, 1, rand_pkt(), 1, 1, 1, 1, y, d, dval);
      if (d && first_dv < 0) first_dv = c;
      if (c >= 5 && c < 25) begin
        ny += int'(y);
        nd += int'(d);
      end
    end
    chk("tput_first_data_cycle", first_dv, 2);
    chk("tput_accepts", ny, 20);
    chk("tput_returns", nd, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_me_cache_pkt_decoupler.md
Name: bp_me_cache_pkt_decoupler

Overview:
- Sits between the L2 cache controller's cache-side port and the bsg_cache instance.
- Buffers outgoing bsg_cache packets and returning cache data, so controller-side and cache-side stalls are decoupled.
- Enforces a credit limit on in-flight requests, so the return-data FIFO never overflows and the cache can always dequeue its data output.
- Order-preserving; carries packets opaquely and never decodes them.

Parameters:
- pkt_width_p, 102: width of the opaque bsg_cache packet (controller computes it from daddr/data widths).
- data_width_p, 64: cache data width, equal to l2_data_width_p.
- els_p, 4: maximum outstanding requests; also the return-data FIFO depth. Must be power of 2, >=2.
- req_els_p, 2: request buffer depth, >=2.

Ports:
- clk_i, input, 1: clock.
- reset_n_i, input, 1: asynchronous active-low reset.
- pkt_i, input, pkt_width_p: packet from the cache controller.
- pkt_v_i, input, 1: packet valid.
- pkt_yumi_o, output, 1: packet consumed this cycle.
- data_o, output, data_width_p: return data toward the controller.
- data_v_o, output, 1: return data valid.
- data_yumi_i, input, 1: controller consumed data_o.
- cache_pkt_o, output, pkt_width_p: packet to bsg_cache.
- cache_pkt_v_o, output, 1: packet valid to cache.
- cache_pkt_yumi_i, input, 1: cache consumed the packet.
- cache_data_i, input, data_width_p: data from bsg_cache.
- cache_data_v_i, input, 1: cache data valid.
- cache_data_yumi_o, output, 1: cache data consumed.
- credits_used_o, output, clog2(els_p+1): requests accepted but not yet returned upstream.

Behaviour:
- Reset: reset_n_i low clears asynchronously:
  - request FIFO and data FIFO pointers;
  - credit counter to 0.
  - While reset is low: pkt_yumi_o=0, cache_pkt_v_o=0, data_v_o=0, cache_data_yumi_o=0, credits_used_o=0.
  - Reset deassertion is synchronized internally by a 2-flop release.
  - Reset mid-operation discards all buffered packets and data; no replay.
- Request path:
  - pkt_yumi_o = pkt_v_i & ~req_full & (credits_used_r != els_p). It is combinational in pkt_v_i only; no dependence on pkt_yumi-style inputs.
  - An accepted packet is written to the request FIFO (depth req_els_p, no bypass).
  - cache_pkt_v_o = ~req_empty. cache_pkt_o = head entry; it is stable while cache_pkt_v_o=1 and cache_pkt_yumi_i=0.
  - Latency from pkt_yumi_o to cache_pkt_v_o is 1 cycle minimum.
  - Enqueue on a full FIFO cannot occur; dequeue on an empty FIFO is a protocol error (assertion).
  - Simultaneous enqueue and dequeue on a full FIFO is permitted only for the dequeue side, because enqueue is blocked when full.
- Return path:
  - cache_data_yumi_o = cache_data_v_i (always accepted). Data is written to a depth-els_p FIFO.
  - data_v_o = ~data_empty; data_o = head entry; dequeue on data_yumi_i.
  - Latency from cache_data_v_i to data_v_o is 1 cycle.
  - cache_data_v_i while the data FIFO is full is impossible under the credit rule; assert an error if it occurs.
- Credits:
  - credits_used_n = credits_used_r + pkt_yumi_o - (data_v_o & data_yumi_i).
  - Accept and retire in the same cycle leaves the count unchanged.
  - Count range is 0..els_p. Overflow or underflow is an assertion failure, and the count saturates rather than wraps.
  - A credit is held from packet acceptance until its data is consumed upstream. This covers TAGST and every op, since bsg_cache returns exactly one data word per packet.
- Ordering: strict FIFO on both paths; the n-th data_o corresponds to the n-th accepted pkt_i.
- Assertions (simulation only):
  - data_yumi_i without data_v_o;
  - cache_pkt_yumi_i without cache_pkt_v_o;
  - credit overflow or underflow.

Test Plan:
- Reset mid-traffic: with 3 packets in flight, pull reset_n_i low for 1 cycle -> all valids 0 immediately, credits_used_o=0. A new packet after release is accepted and its data returned with no stale beats.
- Credit limit (els_p=4): present 6 packets with cache_pkt_yumi_i=1 and cache returning data the next cycle, data_yumi_i=0 -> exactly 4 pkt_yumi_o pulses, credits_used_o=4, pkt_yumi_o then held 0. Assert data_yumi_i for 1 cycle -> 5th packet accepted the following cycle.
- Cache backpressure: cache_pkt_yumi_i=0 for 10 cycles with continuous pkt_v_i -> 2 packets accepted (req FIFO full). cache_pkt_o holds the first packet stable for all 10 cycles.
- Ordering: send packets tagged 0x11..0x14; cache returns data 0xA1..0xA4 with random 0-3 cycle gaps; data_yumi_i random -> data_o sequence is exactly 0xA1, 0xA2, 0xA3, 0xA4.
- Simultaneous accept/retire at credits_used=3: pkt_yumi_o and data_yumi_i in the same cycle -> credits_used_o stays 3.
- Throughput: all ready signals held high -> steady state of one packet accepted and one data returned per cycle, with 2-cycle round-trip latency through the block excluding cache latency.
